// File: rtl/io_in_ctrl_pkg.sv
// Shared definitions for the IO input controller: FSM state encoding and
// default configuration values.
package io_in_ctrl_pkg;

    localparam int IO_IN_DATA_W_DEF       = 32;
    localparam int IO_IN_DEBOUNCE_CYC_DEF = 16;
    localparam int IO_IN_CNT_W_DEF        = 16;

    typedef enum logic [1:0] {
        IO_IN_IDLE = 2'd0,
        IO_IN_WAIT = 2'd1,
        IO_IN_DONE = 2'd2
    } io_in_state_t;

endpackage

// File: rtl/io_in_ctrl_debounce.sv
// io_debounce: two-flop synchronizer, debounce counter and rising-edge pulse
// for the enter pushbutton. After reset the button must first be seen
// released for DEBOUNCE_CYC samples before any press can be reported, so a
// button held through reset never produces an event.
module io_debounce #(
    parameter int DEBOUNCE_CYC = 16,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enter_i,
    output logic enter_db,
    output logic press_o
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic             sync1_r;
    logic             sync2_r;
    logic [1:0]       fill_r;
    logic             armed_r;
    logic [CNT_W-1:0] cnt_r;
    logic             db_r;
    logic             press_r;

    // Synchronize the asynchronous button and track when the synchronizer holds live data.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            fill_r  <= 2'b00;
        end else begin
            sync1_r <= enter_i;
            sync2_r <= sync1_r;
            fill_r  <= {fill_r[0], 1'b1};
        end
    end

    // Arm on a stable release, then debounce the level and emit a pulse on each debounced rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed_r <= 1'b0;
            cnt_r   <= CNT_ZERO;
            db_r    <= 1'b0;
            press_r <= 1'b0;
        end else if (!armed_r) begin
            press_r <= 1'b0;
            if (!fill_r[1] || sync2_r) begin
                cnt_r <= CNT_ZERO;
            end else if (cnt_r == CNT_MAX) begin
                cnt_r   <= CNT_ZERO;
                armed_r <= 1'b1;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end else begin
            if (sync2_r == db_r) begin
                cnt_r   <= CNT_ZERO;
                press_r <= 1'b0;
            end else if (cnt_r == CNT_MAX) begin
                cnt_r   <= CNT_ZERO;
                db_r    <= sync2_r;
                press_r <= sync2_r;
            end else begin
                cnt_r   <= cnt_r + CNT_ONE;
                press_r <= 1'b0;
            end
        end
    end

    assign enter_db = db_r;
    assign press_o  = press_r;

endmodule

// File: rtl/io_in_ctrl.sv
// io_in_ctrl: IO read responder. Stalls the CPU on an IO read until the
// operator presses enter, then returns the switch word with a valid pulse.
// Optional macro IO_IN_PREPRESS_EN: a press while idle is remembered and
// satisfies the next read immediately.
module io_in_ctrl
    import io_in_ctrl_pkg::*;
#(
    parameter int DATA_W       = IO_IN_DATA_W_DEF,
    parameter int DEBOUNCE_CYC = IO_IN_DEBOUNCE_CYC_DEF,
    parameter int CNT_W        = IO_IN_CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re_i,
    input  logic [DATA_W-1:0] data_show_i,
    input  logic              enter_i,
    output logic              stall_req_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              wait_o
);

    io_in_state_t      state_r;
    logic [DATA_W-1:0] data_r;
    logic              valid_r;
    logic              wait_r;
    logic              stall_s;
    logic              enter_db_s;
    logic              press_raw_s;
    logic              press_s;

    io_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .CNT_W        (CNT_W)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .enter_i  (enter_i),
        .enter_db (enter_db_s),
        .press_o  (press_raw_s)
    );

    // A press event always coincides with the debounced level having just gone high.
    assign press_s = press_raw_s & enter_db_s;

`ifdef IO_IN_PREPRESS_EN
    logic              pend_r;
    logic [DATA_W-1:0] hold_r;

    // Remember a press made while idle so the next read can complete at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r <= 1'b0;
            hold_r <= {DATA_W{1'b0}};
        end else if (state_r == IO_IN_IDLE && re_i) begin
            pend_r <= 1'b0;
            hold_r <= hold_r;
        end else if (state_r == IO_IN_IDLE && press_s) begin
            pend_r <= 1'b1;
            hold_r <= data_show_i;
        end else begin
            pend_r <= pend_r;
            hold_r <= hold_r;
        end
    end
`endif

    // Transaction FSM with registered data, valid and prompt outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IO_IN_IDLE;
            data_r  <= {DATA_W{1'b0}};
            valid_r <= 1'b0;
            wait_r  <= 1'b0;
        end else begin
            case (state_r)
                IO_IN_IDLE: begin
`ifdef IO_IN_PREPRESS_EN
                    if (re_i && (pend_r || press_s)) begin
                        state_r <= IO_IN_DONE;
                        data_r  <= pend_r ? hold_r : data_show_i;
                        valid_r <= 1'b1;
                        wait_r  <= 1'b0;
                    end else if (re_i) begin
`else
                    if (re_i) begin
`endif
                        state_r <= IO_IN_WAIT;
                        valid_r <= 1'b0;
                        wait_r  <= 1'b1;
                    end else begin
                        valid_r <= 1'b0;
                        wait_r  <= 1'b0;
                    end
                end
                IO_IN_WAIT: begin
                    if (!re_i) begin
                        state_r <= IO_IN_IDLE;
                        valid_r <= 1'b0;
                        wait_r  <= 1'b0;
                    end else if (press_s) begin
                        state_r <= IO_IN_DONE;
                        data_r  <= data_show_i;
                        valid_r <= 1'b1;
                        wait_r  <= 1'b0;
                    end else begin
                        valid_r <= 1'b0;
                        wait_r  <= 1'b1;
                    end
                end
                IO_IN_DONE: begin
                    state_r <= IO_IN_IDLE;
                    valid_r <= 1'b0;
                    wait_r  <= 1'b0;
                end
                default: begin
                    state_r <= IO_IN_IDLE;
                    valid_r <= 1'b0;
                    wait_r  <= 1'b0;
                end
            endcase
        end
    end

    // Stall from the very cycle a read appears until the captured word is returned.
    always_comb begin
        stall_s = 1'b0;
        if (rst) begin
            stall_s = 1'b0;
        end else if (state_r == IO_IN_WAIT) begin
            stall_s = 1'b1;
        end else if (state_r == IO_IN_IDLE && re_i) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    assign stall_req_o = stall_s;
    assign data_o      = data_r;
    assign valid_o     = valid_r;
    assign wait_o      = wait_r;

endmodule

// File: tb/tb_io_in_ctrl.sv
// Self-checking bench for io_in_ctrl with DEBOUNCE_CYC=4. Expected capture
// words are queued when the press is driven and checked on each valid_o.
module tb_io_in_ctrl;

    logic        clk;
    logic        rst;
    logic        re_i;
    logic [31:0] data_show_i;
    logic        enter_i;
    logic        stall_req_o;
    logic [31:0] data_o;
    logic        valid_o;
    logic        wait_o;

    int          vectors;
    int          miscompares;
    int          valid_count;
    logic [31:0] exp_q[$];

    io_in_ctrl #(
        .DATA_W       (32),
        .DEBOUNCE_CYC (4),
        .CNT_W        (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .re_i        (re_i),
        .data_show_i (data_show_i),
        .enter_i     (enter_i),
        .stall_req_o (stall_req_o),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .wait_o      (wait_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every valid pulse must match the oldest expected capture.
    always @(negedge clk) begin
        if (!rst && valid_o) begin
            logic [31:0] exp_v;
            valid_count++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_valid: data_o=%h, no capture expected", data_o);
            end else begin
                exp_v = exp_q.pop_front();
                if (data_o !== exp_v) begin
                    miscompares++;
                    $display("FAIL capture_data: got %h expected %h", data_o, exp_v);
                end
            end
            vectors++;
            if (stall_req_o !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_in_done: got %b expected 0", stall_req_o);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max_cyc, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid_o && n < max_cyc);
        vectors++;
        if (!valid_o) begin
            miscompares++;
            $display("FAIL %s_timeout: no valid_o within %0d cycles", name, max_cyc);
        end
    endtask

    task automatic expect_no_valid(input int cyc, input string name);
        int c0;
        c0 = valid_count;
        tick(cyc);
        @(negedge clk);
        vectors++;
        if (valid_count != c0) begin
            miscompares++;
            $display("FAIL %s: got %0d valid pulses expected 0", name, valid_count - c0);
        end
    endtask

    task automatic check_stall(input logic exp, input string name);
        @(negedge clk);
        vectors++;
        if (stall_req_o !== exp) begin
            miscompares++;
            $display("FAIL %s: stall_req_o=%b expected %b", name, stall_req_o, exp);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; re_i = 1'b1; enter_i = 1'b1; data_show_i = 32'h0000_0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({stall_req_o, valid_o, wait_o, data_o} !== 35'd0) begin
                miscompares++;
                $display("FAIL reset_outputs: stall=%b valid=%b wait=%b data=%h expected all 0",
                         stall_req_o, valid_o, wait_o, data_o);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        check_stall(1'b1, "stall_after_reset");
        expect_no_valid(15, "held_through_reset");
        vectors++;
        if (wait_o !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_prompt: wait_o=%b expected 1", wait_o);
        end
        tick(1);
        enter_i = 1'b0;
        expect_no_valid(8, "release_after_reset");
        tick(1);
        exp_q.push_back(32'h0000_0001);
        enter_i = 1'b1;
        wait_valid(20, "repress_after_reset");
        re_i = 1'b0;
        tick(1);
        enter_i = 1'b0;
        tick(10);
    endtask

    task automatic test_basic;
        data_show_i = 32'h0000_00A5;
        re_i = 1'b1;
        check_stall(1'b1, "basic_stall_same_cycle");
        tick(3);
        exp_q.push_back(32'h0000_00A5);
        enter_i = 1'b1;
        wait_valid(12, "basic_read");
        re_i = 1'b0;
        tick(1);
        enter_i = 1'b0;
        check_stall(1'b0, "basic_idle_no_stall");
        tick(10);
    endtask

    task automatic test_bounce;
        int c0;
        data_show_i = 32'h0000_5A5A;
        re_i = 1'b1;
        c0 = valid_count;
        for (int i = 0; i < 6; i++) begin
            enter_i = ~enter_i;
            tick(2);
        end
        vectors++;
        if (valid_count != c0) begin
            miscompares++;
            $display("FAIL bounce_no_capture: got %0d valid pulses expected 0", valid_count - c0);
        end
        exp_q.push_back(32'h0000_5A5A);
        enter_i = 1'b1;
        wait_valid(15, "bounce_settle");
        re_i = 1'b0;
        tick(1);
        enter_i = 1'b0;
        tick(10);
    endtask

    task automatic test_back_to_back;
        data_show_i = 32'h1111_0000;
        re_i = 1'b1;
        tick(1);
        exp_q.push_back(32'h1111_0000);
        enter_i = 1'b1;
        wait_valid(15, "b2b_first");
        tick(1);
        data_show_i = 32'h1234_5678;
        expect_no_valid(15, "b2b_held_no_second");
        check_stall(1'b1, "b2b_held_stall");
        tick(1);
        enter_i = 1'b0;
        expect_no_valid(8, "b2b_release");
        tick(1);
        exp_q.push_back(32'h1234_5678);
        enter_i = 1'b1;
        wait_valid(15, "b2b_second");
        re_i = 1'b0;
        tick(1);
        enter_i = 1'b0;
        tick(10);
    endtask

    task automatic test_abort;
        re_i = 1'b1;
        tick(3);
        @(negedge clk);
        vectors++;
        if (wait_o !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_wait_prompt: wait_o=%b expected 1", wait_o);
        end
        tick(1);
        re_i = 1'b0;
        data_show_i = 32'hCAFE_0000;
        enter_i = 1'b1;
        expect_no_valid(15, "abort_no_valid");
        vectors++;
        if (data_o !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL abort_data_kept: got %h expected 12345678", data_o);
        end
        vectors++;
        if (stall_req_o !== 1'b0 || wait_o !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle: stall=%b wait=%b expected 0 0", stall_req_o, wait_o);
        end
        tick(1);
        enter_i = 1'b0;
        tick(10);
    endtask

    task automatic test_prepress;
        data_show_i = 32'hDEAD_BEEF;
        enter_i = 1'b1;
        tick(12);
        enter_i = 1'b0;
        data_show_i = 32'h0000_0000;
        tick(10);
`ifdef IO_IN_PREPRESS_EN
        exp_q.push_back(32'hDEAD_BEEF);
        re_i = 1'b1;
        check_stall(1'b1, "prepress_stall_once");
        wait_valid(2, "prepress_read");
        re_i = 1'b0;
        check_stall(1'b0, "prepress_after");
`else
        re_i = 1'b1;
        expect_no_valid(10, "prepress_dropped");
        check_stall(1'b1, "prepress_dropped_stall");
        tick(1);
        exp_q.push_back(32'h0000_0000);
        enter_i = 1'b1;
        wait_valid(15, "prepress_new_press");
        re_i = 1'b0;
        tick(1);
        enter_i = 1'b0;
`endif
        tick(5);
    endtask

    initial begin
        vectors = 0; miscompares = 0; valid_count = 0;
        rst = 1'b1; re_i = 1'b0; enter_i = 1'b0; data_show_i = 32'h0;
        test_reset();
        test_basic();
        test_bounce();
        test_back_to_back();
        test_abort();
        test_prepress();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_valid: %0d expected captures never returned", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/io_in_ctrl.md
Name: io_in_ctrl

Overview:
Input-side responder for the CPU's IO read path; the complement of the existing IO output unit. On a CPU IO read it holds the pipeline stalled until the operator presses the enter button. It then captures the switch word and returns it to the CPU with a one-cycle valid pulse. Sits in the SOPC top between board switches/button and the openmips IO read port.

Parameters:
DATA_W, 32, width of switch word and returned data (matches `RegBus)
DEBOUNCE_CYC, 16, consecutive stable synchronized samples required to change debounced enter level (>=2)
CNT_W, 16, width of debounce counter; must hold DEBOUNCE_CYC

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
re_i  input  1  CPU IO read request; held high until valid_o seen
data_show_i  input  DATA_W  raw switch word from board
enter_i  input  1  raw asynchronous enter pushbutton, active-high
stall_req_o  output  1  stall request to CPU pipeline control
data_o  output  DATA_W  captured switch word to CPU
valid_o  output  1  one-cycle pulse: data_o holds the newly captured word
wait_o  output  1  operator prompt (LED): high while waiting for a press

Behaviour:
- Single clock domain, clk; all state updates on rising edge; rst synchronous, active-high.
- Reset: state IDLE, data_o=0, valid_o=0, wait_o=0, stall_req_o=0, sync flops=0, debounce counter=0, enter_db=0.
- Input conditioning: enter_i passes a 2-flop synchronizer. enter_db changes only after DEBOUNCE_CYC consecutive cycles with synchronized level != enter_db. Counter clears on any sample equal to enter_db.
- Press event: one-cycle pulse on enter_db 0->1. Held button yields exactly one event; release yields none.
- Latency: enter_i stable high from cycle k -> press event at cycle k+2+DEBOUNCE_CYC (+/-1 with sampling phase).
- FSM states: IDLE, WAIT_PRESS, DONE.
  IDLE: re_i=1 -> WAIT_PRESS. Press events are ignored (see optional feature).
  WAIT_PRESS: wait_o=1. Press event -> data_o<=data_show_i sampled that cycle, go DONE. re_i=0 (CPU flush/abort) -> IDLE, data_o unchanged, no valid_o. If press and re_i=0 occur in the same cycle, abort wins.
  DONE: valid_o=1 for exactly this cycle, then unconditionally -> IDLE.
- stall_req_o is combinational: 1 when (state==IDLE && re_i) or state==WAIT_PRESS; 0 in DONE. The CPU is stalled from the same cycle re_i rises.
- Back-to-back reads: re_i still high in the cycle after DONE starts a new transaction. It needs a new press event; a button still held from the previous press does not satisfy it.
- data_o holds its last captured value between transactions. data_show_i is not registered except at capture.
- Reset mid-operation: returns to IDLE next edge. Any in-progress debounce is discarded, and a button held through reset deasserting must be released and pressed again.

Optional Feature:
IO_IN_PREPRESS_EN
- Defined: a press event in IDLE sets a pending flag and captures data_show_i into a holding register. The next re_i in IDLE goes directly to DONE; data_o<=holding register and the pending flag clears. stall_req_o is high for that one IDLE cycle only. A second press while pending overwrites the holding register. Reset clears the pending flag.
- Undefined: no pending flag or holding register. IDLE presses are dropped, as in Behaviour.

Decomposition:
- defines.v: FSM state encodings (IO_IN_IDLE, IO_IN_WAIT, IO_IN_DONE) and DEBOUNCE_CYC default macro; data width uses existing `RegBus.
- One sub-module, io_debounce: synchronizer, debounce counter, and rising-edge pulse. Outputs enter_db and press_o; parameters DEBOUNCE_CYC and CNT_W.

Test Plan:
(DEBOUNCE_CYC=4 for all tests.)
- Reset check: rst high 3 cycles with re_i=1, enter_i=1 -> all outputs 0 during reset; after release, stall_req_o=1 and no valid_o until enter_i drops then rises again.
- Basic read: re_i=1, data_show_i=32'h0000_00A5, enter_i high from cycle 10 -> stall_req_o=1 from re_i cycle; valid_o pulses once at ~cycle 16-17 with data_o=32'h0000_00A5; stall_req_o=0 that cycle.
- Bounce: enter_i toggles every 2 cycles for 12 cycles, then stays high -> no capture during toggling; exactly one valid_o once high held >=4 synced cycles.
- Held button, two reads: first read completes; re_i stays high while enter_i stays high -> stall_req_o remains 1, no second valid_o until release (>=4 cycles low) and re-press; second capture returns the current data_show_i (32'h1234_5678).
- Abort: re_i drops in WAIT_PRESS, then press -> no valid_o, data_o unchanged, state IDLE.
- IO_IN_PREPRESS_EN: press in IDLE with data_show_i=32'hDEAD_BEEF, then switches change to 0, then re_i=1 -> valid_o next cycle with data_o=32'hDEAD_BEEF, one stall cycle. Without the macro: same stimulus waits for a new press.
